font_rom_arbiter: RTL and testbench
===================================

FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, meaning the number of text requesters sharing one font ROM (legal range 2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 11, meaning the font ROM address width, {char_code[6:0], char_line[3:0]}.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 module_en  input  1  arbitration enable; low blocks new grants.
REQ-006 req  input  NUM_REQ  per-requester lookup request, held until granted.
REQ-007 addr_in  input  NUM_REQ*ADDR_W  packed per-requester ROM address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 rom_addr  output  ADDR_W  registered address to the shared synchronous font ROM.
REQ-009 rom_data  input  8  ROM line pixels, valid one clk after rom_addr.
REQ-010 gnt  output  NUM_REQ  registered one-hot grant.
REQ-011 rsp_valid  output  NUM_REQ  one-hot response strobe.
REQ-012 rsp_data  output  8  returned char_line_pixels; valid only while rsp_valid is non-zero.

Function
REQ-013 The block SHALL evaluate req every cycle and, when module_en=1 and any req bit is set, register exactly one gnt bit and the winner's addr_in slice into rom_addr on the same edge.
REQ-014 The block SHALL assert at most one gnt bit per cycle and SHALL hold gnt high for exactly one cycle per grant.
REQ-015 The block SHALL allow a requester to be re-granted in consecutive cycles when it is the only requester.
REQ-016 The block SHALL use round-robin priority: search starts at (last_grant+1) mod NUM_REQ, and the pointer wraps from NUM_REQ-1 to 0.
REQ-017 The block SHALL advance the round-robin pointer only on a cycle in which a grant is issued.
REQ-018 The block SHALL present rsp_valid (one-hot, same bit as the grant) and rsp_data=rom_data exactly 2 cycles after the edge that set gnt, using a 2-stage valid/tag pipeline.
REQ-019 The block SHALL sustain one response per cycle with full pipeline overlap, with no bubbles while requests are pending.
REQ-020 A requester SHALL treat its own gnt=1 as acceptance, and SHALL present a new address or drop req on the following cycle.
REQ-021 A req bit dropped before its grant SHALL produce neither a grant nor a response.
REQ-022 The block SHALL let responses already in the pipeline complete while module_en=0, SHALL issue no new grants, and SHALL hold the pointer.
REQ-023 When no grant is issued, gnt SHALL be 0 and rom_addr SHALL hold its previous value.
REQ-024 rsp_data SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-025 On rst=0 the block SHALL immediately clear gnt, rsp_valid, rsp_data, rom_addr and both pipeline stages to 0, and SHALL set the pointer so requester 0 has the highest priority.
REQ-026 The block SHALL discard in-flight lookups when reset is asserted mid-operation; no rsp_valid is produced for them after reset release.
REQ-027 The first grant SHALL be issued on the first rising edge after rst deasserts with module_en=1 and req non-zero.

Configuration
REQ-028 The block SHALL use macro FONT_ARB_FIXED_PRIO_EN to select the arbitration policy:
- Defined: fixed priority, lowest index wins; the pointer logic is removed.
- Undefined: round-robin per REQ-016/REQ-017.
All other timing is identical in both builds.

Verification
REQ-029 Reset, then req=3'b001 with addr_in[0]=11'h2A5 held for 1 cycle -> gnt=001 one cycle later, rom_addr=11'h2A5, rsp_valid=001 two cycles after gnt, rsp_data=ROM[11'h2A5].
REQ-030 req=3'b111 held for 6 cycles, round-robin build -> gnt sequence 001,010,100,001,010,100; rsp_valid shows the same sequence delayed 2 cycles.
REQ-031 Same stimulus as REQ-030 with FONT_ARB_FIXED_PRIO_EN defined -> gnt=001 on every cycle; requesters 1 and 2 are never granted.
REQ-032 Grants in flight, then module_en=0 for 4 cycles with req=3'b110 -> two pending rsp_valid pulses complete, gnt=000 throughout; after re-enable the next gnt resumes from the held pointer.
REQ-033 rst pulsed low for 1 cycle while two lookups are in flight -> outputs 0 immediately, no rsp_valid for those lookups, and the next grant goes to requester 0 when req=3'b111.
REQ-034 req[1] raised and dropped before winning while req[0] is held high -> no gnt[1] and no rsp_valid[1] observed.

Source files
------------

// File: rtl/font_rom_arbiter_if.sv
// Requester-side bus of the font ROM arbiter: per-requester request/address in,
// one-hot grant and response strobe plus returned pixel line out.
interface font_rom_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 11
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] addr_in;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [7:0]                rsp_data;

   modport master (
      output req,
      output addr_in,
      input  gnt,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req,
      input  addr_in,
      output gnt,
      output rsp_valid,
      output rsp_data
   );
endinterface

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM among NUM_REQ text requesters; responses return 2 cycles after grant.
// Policy macro FONT_ARB_FIXED_PRIO_EN: defined = fixed priority (lowest index), undefined = round-robin.
module font_rom_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              module_en,
   font_rom_arbiter_if.slave bus,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] gnt_r;
   logic [NUM_REQ-1:0] stage1_r;
   logic [NUM_REQ-1:0] rsp_valid_r;
   logic [7:0]         rsp_data_r;
   logic [ADDR_W-1:0]  rom_addr_r;

   logic [NUM_REQ-1:0] gnt_next_s;
   logic [ADDR_W-1:0]  win_addr_s;
   logic [IDX_W-1:0]   win_idx_s;
   logic               win_found_s;

`ifdef FONT_ARB_FIXED_PRIO_EN
   // Winner select: scan downward so the lowest requesting index is the last to overwrite.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         win_idx_s   = bus.req[k] ? IDX_W'(k) : win_idx_s;
         win_found_s = win_found_s | bus.req[k];
      end
   end
`else
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W:0]   cand_s;
   logic             hit_s;

   // Winner select: first requester found searching from the slot after the last grant.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      hit_s       = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s      = {1'b0, ptr_r} + (IDX_W + 1)'(k);
         cand_s      = (cand_s >= (IDX_W + 1)'(NUM_REQ)) ? (cand_s - (IDX_W + 1)'(NUM_REQ)) : cand_s;
         hit_s       = bus.req[cand_s[IDX_W-1:0]] & ~win_found_s;
         win_idx_s   = hit_s ? cand_s[IDX_W-1:0] : win_idx_s;
         win_found_s = win_found_s | hit_s;
      end
   end

   // Round-robin pointer: remembers the last granted index, moves only when a grant issues.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r <= IDX_W'(NUM_REQ - 1);
      end else if (|gnt_next_s) begin
         ptr_r <= win_idx_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end
`endif

   // Next grant vector and the winner's address slice.
   always_comb begin
      gnt_next_s = '0;
      win_addr_s = bus.addr_in[int'(win_idx_s)*ADDR_W +: ADDR_W];
      if (module_en && win_found_s) begin
         gnt_next_s[win_idx_s] = 1'b1;
      end else begin
         gnt_next_s = '0;
      end
   end

   // Grant/address registers and the 2-stage tag pipeline aligned with the ROM read latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_r       <= '0;
         rom_addr_r  <= '0;
         stage1_r    <= '0;
         rsp_valid_r <= '0;
         rsp_data_r  <= 8'h00;
      end else begin
         gnt_r       <= gnt_next_s;
         rom_addr_r  <= (|gnt_next_s) ? win_addr_s : rom_addr_r;
         stage1_r    <= gnt_r;
         rsp_valid_r <= stage1_r;
         rsp_data_r  <= (|stage1_r) ? rom_data : 8'h00;
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign rom_addr      = rom_addr_r;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed, table-driven bench for font_rom_arbiter (3 requesters) with a synchronous ROM model.
module tb_font_rom_arbiter;

`ifdef FONT_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   localparam logic [10:0] A0 = 11'h2A5;
   localparam logic [10:0] A1 = 11'h13C;
   localparam logic [10:0] A2 = 11'h7F1;
   localparam logic [10:0] A1B = 11'h055;

   typedef struct {
      logic        en;
      logic [2:0]  req;
      logic [32:0] addr;
      logic [2:0]  gnt;
      logic [10:0] rom_addr;
      logic [2:0]  rsp;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        module_en;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;

   int errors;
   int checks;
   vec_t vq[$];

   font_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(11)) bus ();

   font_rom_arbiter #(.NUM_REQ(3), .ADDR_W(11)) dut (
      .clk       (clk),
      .rst       (rst),
      .module_en (module_en),
      .bus       (bus),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   function automatic logic [7:0] rom_fn(input logic [10:0] a);
      return a[7:0] ^ {a[10:8], 5'b10110};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic en, input logic [2:0] req, input logic [10:0] a1,
                               input logic [2:0] g, input logic [10:0] ra, input logic [2:0] rs);
      vec_t v;
      v.en = en; v.req = req; v.addr = {A2, a1, A0};
      v.gnt = g; v.rom_addr = ra; v.rsp = rs;
      return v;
   endfunction

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      module_en = 1'b0;
      bus.req = 3'b000;
      bus.addr_in = {A2, A1, A0};

      // All-requesters round robin (fixed build: requester 0 every time), then drain
      vq.push_back(mk(1'b1, 3'b111, A1, 3'b001, A0, 3'b000));
      vq.push_back(mk(1'b1, 3'b111, A1, FIXED ? 3'b001 : 3'b010, FIXED ? A0 : A1, 3'b000));
      vq.push_back(mk(1'b1, 3'b111, A1, FIXED ? 3'b001 : 3'b100, FIXED ? A0 : A2, 3'b001));
      vq.push_back(mk(1'b1, 3'b111, A1, 3'b001, A0, FIXED ? 3'b001 : 3'b010));
      vq.push_back(mk(1'b1, 3'b111, A1, FIXED ? 3'b001 : 3'b010, FIXED ? A0 : A1, FIXED ? 3'b001 : 3'b100));
      vq.push_back(mk(1'b1, 3'b111, A1, FIXED ? 3'b001 : 3'b100, FIXED ? A0 : A2, 3'b001));
      vq.push_back(mk(1'b1, 3'b000, A1, 3'b000, FIXED ? A0 : A2, FIXED ? 3'b001 : 3'b010));
      vq.push_back(mk(1'b1, 3'b000, A1, 3'b000, FIXED ? A0 : A2, FIXED ? 3'b001 : 3'b100));
      vq.push_back(mk(1'b1, 3'b000, A1, 3'b000, FIXED ? A0 : A2, 3'b000));
      // Lone requester re-granted back to back with a new address
      vq.push_back(mk(1'b1, 3'b010, A1,  3'b010, A1,  3'b000));
      vq.push_back(mk(1'b1, 3'b010, A1B, 3'b010, A1B, 3'b000));
      vq.push_back(mk(1'b1, 3'b000, A1B, 3'b000, A1B, 3'b010));
      vq.push_back(mk(1'b1, 3'b000, A1B, 3'b000, A1B, 3'b010));
      vq.push_back(mk(1'b1, 3'b000, A1B, 3'b000, A1B, 3'b000));
      // Disable with grants in flight, then resume from held pointer
      vq.push_back(mk(1'b1, 3'b111, A1, FIXED ? 3'b001 : 3'b100, FIXED ? A0 : A2, 3'b000));
      vq.push_back(mk(1'b1, 3'b111, A1, 3'b001, A0, 3'b000));
      vq.push_back(mk(1'b0, 3'b110, A1, 3'b000, A0, FIXED ? 3'b001 : 3'b100));
      vq.push_back(mk(1'b0, 3'b110, A1, 3'b000, A0, 3'b001));
      vq.push_back(mk(1'b0, 3'b110, A1, 3'b000, A0, 3'b000));
      vq.push_back(mk(1'b0, 3'b110, A1, 3'b000, A0, 3'b000));
      vq.push_back(mk(1'b1, 3'b110, A1, 3'b010, A1, 3'b000));
      vq.push_back(mk(1'b1, 3'b110, A1, FIXED ? 3'b010 : 3'b100, FIXED ? A1 : A2, 3'b000));
      vq.push_back(mk(1'b1, 3'b000, A1, 3'b000, FIXED ? A1 : A2, 3'b010));
      vq.push_back(mk(1'b1, 3'b000, A1, 3'b000, FIXED ? A1 : A2, FIXED ? 3'b010 : 3'b100));
      vq.push_back(mk(1'b1, 3'b000, A1, 3'b000, FIXED ? A1 : A2, 3'b000));
      // Requester 1 raised and dropped before winning while requester 0 holds
      vq.push_back(mk(1'b1, 3'b011, A1, 3'b001, A0, 3'b000));
      vq.push_back(mk(1'b1, 3'b001, A1, 3'b001, A0, 3'b000));
      vq.push_back(mk(1'b1, 3'b000, A1, 3'b000, A0, 3'b001));
      vq.push_back(mk(1'b1, 3'b000, A1, 3'b000, A0, 3'b001));
      vq.push_back(mk(1'b1, 3'b000, A1, 3'b000, A0, 3'b000));

      // Reset state
      #12;
      chk("reset_gnt", 32'(bus.gnt), 32'd0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("reset_rom_addr", 32'(rom_addr), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         module_en   = vq[i].en;
         bus.req     = vq[i].req;
         bus.addr_in = vq[i].addr;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(vq[i].gnt));
         chk($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vq[i].rom_addr));
         chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vq[i].rsp));
         chk($sformatf("v%0d_rsp_data", i), 32'(bus.rsp_data),
             (vq[i].rsp != 3'b000 && i >= 2) ? 32'(rom_fn(vq[i-2].rom_addr)) : 32'd0);
      end

      // Reset asserted with two lookups in flight
      module_en = 1'b1;
      bus.addr_in = {A2, A1, A0};
      bus.req = 3'b100;
      @(posedge clk);
      #1;
      chk("mid_gnt0", 32'(bus.gnt), 32'b100);
      bus.req = 3'b010;
      @(posedge clk);
      #1;
      chk("mid_gnt1", 32'(bus.gnt), 32'b010);
      chk("mid_addr1", 32'(rom_addr), 32'(A1));
      rst = 1'b0;
      bus.req = 3'b000;
      #1;
      chk("rst_async_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_async_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_async_rom_addr", 32'(rom_addr), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_rst_rsp_valid%0d", i), 32'(bus.rsp_valid), 32'd0);
         chk($sformatf("post_rst_gnt%0d", i), 32'(bus.gnt), 32'd0);
      end
      bus.req = 3'b111;
      @(posedge clk);
      #1;
      chk("post_rst_first_gnt", 32'(bus.gnt), 32'b001);
      chk("post_rst_first_addr", 32'(rom_addr), 32'(A0));
      bus.req = 3'b000;
      @(posedge clk);
      #1;
      chk("post_rst_gnt_clear", 32'(bus.gnt), 32'd0);
      @(posedge clk);
      #1;
      chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'b001);
      chk("post_rst_rsp_data", 32'(bus.rsp_data), 32'(rom_fn(A0)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
